ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 194 +++++++++++++++++++
 tb/tb_ifetch_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: a single-outstanding icache requester feeding
// an in-order instruction queue that the decoder drains.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no request outstanding
// WAIT  | request to icache_addr outstanding, response will be enqueued
// DROP  | stale request outstanding after a redirect, response discarded
module ifetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        icache_req,
  output logic [ADDR_W-1:0]           icache_addr,
  input  logic                        icache_valid,
  input  logic [INSTR_W-1:0]          icache_instr,
  input  logic                        pred_taken,
  input  logic [ADDR_W-1:0]           pred_target,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [INSTR_W-1:0]          dec_instr,
  output logic [ADDR_W-1:0]           dec_pc,
  output logic                        dec_pred_taken,
  output logic [$clog2(DEPTH):0]      queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  logic [INSTR_W-1:0]  mem_instr [DEPTH];
  logic [ADDR_W-1:0]   mem_pc    [DEPTH];
  logic                mem_pt    [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                deq_req;
  logic                do_enq, do_deq, flush;
  logic [CNT_W-1:0]    cnt_less_deq, cnt_after_enq;
  logic [ADDR_W-1:0]   next_pc;

  assign deq_req        = dec_valid & dec_ready;
  assign dec_valid      = (count_q != '0);
  assign dec_instr      = mem_instr[rd_ptr_q];
  assign dec_pc         = mem_pc[rd_ptr_q];
  assign dec_pred_taken = mem_pt[rd_ptr_q];
  assign queue_count    = count_q;
  assign icache_req     = req_q;
  assign icache_addr    = addr_q;

  // Next-state, fetch pc and queue-operation decode; redirect beats everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_d         = req_q;
    addr_d        = addr_q;
    do_enq        = 1'b0;
    do_deq        = 1'b0;
    flush         = 1'b0;
    // Reservation counts the slot freed by a same-cycle dequeue, and in the
    // back-to-back case also the slot taken by the response arriving now.
    cnt_less_deq  = count_q - {{(CNT_W-1){1'b0}}, deq_req};
    cnt_after_enq = cnt_less_deq + {{(CNT_W-1){1'b0}}, 1'b1};
    next_pc       = pred_taken ? pred_target : pc_q + ADDR_W'(4);
    if (rdy) begin
      if (redirect_valid) begin
        flush = 1'b1;
        pc_d  = redirect_pc;
        case (state_q)
          S_WAIT: begin
            if (icache_valid) begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end else begin
              state_d = S_DROP;
            end
          end
          // A response arriving together with the redirect still retires the
          // stale request; waiting for another one would never complete.
          S_DROP: begin
            if (icache_valid) begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
          default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        endcase
      end else begin
        do_deq = deq_req;
        case (state_q)
          S_IDLE: begin
            if (cnt_less_deq < DEPTH_C) begin
              state_d = S_WAIT;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
          S_WAIT: begin
            if (icache_valid) begin
              do_enq = 1'b1;
              pc_d   = next_pc;
              if (cnt_after_enq < DEPTH_C) begin
                addr_d = next_pc;
              end else begin
                state_d = S_IDLE;
                req_d   = 1'b0;
              end
            end
          end
          S_DROP: begin
            if (icache_valid) begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
          default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // FSM, fetch pc and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // Queue storage, pointers and occupancy; a flush empties it in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
        mem_pt[i]    <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) begin
        mem_instr[wr_ptr_q] <= icache_instr;
        mem_pc[wr_ptr_q]    <= addr_q;
        mem_pt[wr_ptr_q]    <= pred_taken;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_enq && !do_deq) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_enq && do_deq) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: per-cycle vector table for the main
// fetch/redirect/stall flow, then hand sequences for reset, fill and drain.
module tb_ifetch_queue;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_instr;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic [3:0]  queue_count;

  int errors = 0;
  int checks = 0;

  ifetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_valid   (icache_valid),
    .icache_instr   (icache_instr),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pred_taken (dec_pred_taken),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        iv;
    logic        pt;
    logic [31:0] ptgt;
    logic        drdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_dpc;
    logic        e_dpt;
    logic [3:0]  e_cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic iv, input logic pt, input logic [31:0] tgt,
                              input logic drdy, input logic ereq, input logic [31:0] ea,
                              input logic edv, input logic [31:0] edpc, input logic edpt,
                              input logic [3:0] ecnt);
    vec_t v;
    v.rdy = r; v.redir = rd; v.rpc = rpc; v.iv = iv; v.pt = pt; v.ptgt = tgt;
    v.drdy = drdy; v.e_req = ereq; v.e_addr = ea; v.e_dv = edv; v.e_dpc = edpc;
    v.e_dpt = edpt; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; icache_valid = 1'b0;
    icache_instr = '0; pred_taken = 1'b0; pred_target = '0;
  endtask

  // Answers any outstanding request in the same cycle with a tagged instruction.
  task automatic respond(input int cycles, output int enq_seen, output int ovf);
    enq_seen = 0;
    ovf = 0;
    for (int c = 0; c < cycles; c++) begin
      icache_valid = icache_req;
      icache_instr = icache_addr | TAG;
      if (icache_req) enq_seen++;
      if (queue_count > 4'd8) ovf++;
      step();
    end
    icache_valid = 1'b0;
  endtask

  initial begin
    int enq_seen, ovf, n;
    logic [31:0] exp_pc;

    //        rdy rd rpc     iv pt tgt     drdy| req addr    dv dpc     dpt cnt
    vt[0]  = mk(1, 0, 0,      0, 0, 0,      1,   0, 32'h000, 0, 32'h000, 0, 0);
    vt[1]  = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h000, 0, 32'h000, 0, 0);
    vt[2]  = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h004, 1, 32'h000, 0, 1);
    vt[3]  = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h008, 1, 32'h004, 0, 1);
    vt[4]  = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h00C, 1, 32'h008, 0, 1);
    vt[5]  = mk(1, 0, 0,      1, 1, 32'h100, 1,  1, 32'h010, 1, 32'h00C, 0, 1);
    vt[6]  = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h100, 1, 32'h010, 1, 1);
    vt[7]  = mk(1, 0, 0,      0, 0, 0,      0,   1, 32'h104, 1, 32'h100, 0, 1);
    vt[8]  = mk(0, 0, 0,      1, 0, 0,      1,   1, 32'h104, 1, 32'h100, 0, 1);
    vt[9]  = mk(0, 0, 0,      1, 0, 0,      1,   1, 32'h104, 1, 32'h100, 0, 1);
    vt[10] = mk(0, 0, 0,      1, 0, 0,      1,   1, 32'h104, 1, 32'h100, 0, 1);
    vt[11] = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h104, 1, 32'h100, 0, 1);
    vt[12] = mk(1, 0, 0,      0, 0, 0,      0,   1, 32'h108, 1, 32'h104, 0, 1);
    vt[13] = mk(1, 1, 32'h200, 0, 0, 0,     1,   1, 32'h108, 1, 32'h104, 0, 1);
    vt[14] = mk(1, 0, 0,      0, 0, 0,      1,   1, 32'h108, 0, 32'h000, 0, 0);
    vt[15] = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h108, 0, 32'h000, 0, 0);
    vt[16] = mk(1, 0, 0,      0, 0, 0,      1,   0, 32'h108, 0, 32'h000, 0, 0);
    vt[17] = mk(1, 0, 0,      0, 0, 0,      1,   1, 32'h200, 0, 32'h000, 0, 0);
    vt[18] = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h200, 0, 32'h000, 0, 0);
    vt[19] = mk(1, 1, 32'h300, 1, 0, 0,     1,   1, 32'h204, 1, 32'h200, 0, 1);
    vt[20] = mk(1, 0, 0,      0, 0, 0,      1,   0, 32'h204, 0, 32'h000, 0, 0);
    vt[21] = mk(1, 0, 0,      0, 0, 0,      1,   1, 32'h300, 0, 32'h000, 0, 0);
    vt[22] = mk(1, 1, 32'h400, 0, 0, 0,     1,   1, 32'h300, 0, 32'h000, 0, 0);
    vt[23] = mk(1, 1, 32'h500, 0, 0, 0,     1,   1, 32'h300, 0, 32'h000, 0, 0);
    vt[24] = mk(1, 0, 0,      1, 0, 0,      1,   1, 32'h300, 0, 32'h000, 0, 0);
    vt[25] = mk(1, 0, 0,      0, 0, 0,      1,   0, 32'h300, 0, 32'h000, 0, 0);
    vt[26] = mk(1, 0, 0,      0, 0, 0,      1,   1, 32'h500, 0, 32'h000, 0, 0);

    idle_inputs();
    dec_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Vector table: compare state at cycle start, then apply that cycle's inputs.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d icache_req", i), {31'b0, icache_req}, {31'b0, vt[i].e_req});
      chk($sformatf("v%0d icache_addr", i), icache_addr, vt[i].e_addr);
      chk($sformatf("v%0d dec_valid", i), {31'b0, dec_valid}, {31'b0, vt[i].e_dv});
      chk($sformatf("v%0d queue_count", i), {28'b0, queue_count}, {28'b0, vt[i].e_cnt});
      if (vt[i].e_dv) begin
        chk($sformatf("v%0d dec_pc", i), dec_pc, vt[i].e_dpc);
        chk($sformatf("v%0d dec_instr", i), dec_instr, vt[i].e_dpc | TAG);
        chk($sformatf("v%0d dec_pred_taken", i), {31'b0, dec_pred_taken}, {31'b0, vt[i].e_dpt});
      end
      rdy            = vt[i].rdy;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      icache_valid   = vt[i].iv;
      icache_instr   = vt[i].e_addr | TAG;
      pred_taken     = vt[i].pt;
      pred_target    = vt[i].ptgt;
      dec_ready      = vt[i].drdy;
      step();
    end

    // Reset dominates rdy=0 and a redirect, and clears every output.
    idle_inputs();
    rdy = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h700;
    rst = 1'b1;
    step();
    step();
    chk("rst icache_req", {31'b0, icache_req}, 32'd0);
    chk("rst icache_addr", icache_addr, 32'd0);
    chk("rst dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst dec_pc", dec_pc, 32'd0);
    chk("rst dec_instr", dec_instr, 32'd0);
    chk("rst dec_pred_taken", {31'b0, dec_pred_taken}, 32'd0);
    chk("rst queue_count", {28'b0, queue_count}, 32'd0);
    idle_inputs();
    rst = 1'b0;
    chk("post-rst cycle0 req", {31'b0, icache_req}, 32'd0);
    step();
    chk("post-rst cycle1 req", {31'b0, icache_req}, 32'd1);
    chk("post-rst cycle1 addr", icache_addr, 32'h0);

    // Reset mid-WAIT, then a stale response while IDLE must not be enqueued.
    rst = 1'b1;
    step();
    rst = 1'b0;
    icache_valid = 1'b1;
    icache_instr = 32'hDEAD_BEEF;
    step();
    icache_valid = 1'b0;
    chk("stale count", {28'b0, queue_count}, 32'd0);
    chk("stale dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("stale req", {31'b0, icache_req}, 32'd1);
    chk("stale addr", icache_addr, 32'h0);

    // Fill with decoder stalled: exactly DEPTH entries, then no more requests.
    dec_ready = 1'b0;
    respond(30, enq_seen, ovf);
    chk("fill enq count", enq_seen, 32'd8);
    chk("fill queue_count", {28'b0, queue_count}, 32'd8);
    chk("fill req idle", {31'b0, icache_req}, 32'd0);
    chk("fill head pc", dec_pc, 32'h0);
    chk("fill overflow", ovf, 32'd0);

    // Drain while fetching continues: strictly sequential pcs, no loss or repeat.
    dec_ready = 1'b1;
    exp_pc = 32'h0;
    n = 0;
    for (int c = 0; c < 200 && n < 24; c++) begin
      if (dec_valid) begin
        chk($sformatf("drain%0d dec_pc", n), dec_pc, exp_pc);
        chk($sformatf("drain%0d dec_instr", n), dec_instr, exp_pc | TAG);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      icache_valid = icache_req;
      icache_instr = icache_addr | TAG;
      step();
    end
    icache_valid = 1'b0;
    chk("drain budget", n, 32'd24);

    // Refill, then redirect while IDLE with a full queue.
    dec_ready = 1'b0;
    respond(40, enq_seen, ovf);
    chk("refill queue_count", {28'b0, queue_count}, 32'd8);
    chk("refill req idle", {31'b0, icache_req}, 32'd0);
    chk("refill overflow", ovf, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("idle redir count", {28'b0, queue_count}, 32'd0);
    chk("idle redir dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("idle redir req", {31'b0, icache_req}, 32'd0);
    step();
    chk("idle redir new req", {31'b0, icache_req}, 32'd1);
    chk("idle redir new addr", icache_addr, 32'h200);

    // Redirect coincident with a response and an accepting decoder.
    dec_ready = 1'b1;
    icache_valid = 1'b1;
    icache_instr = 32'h200 | TAG;
    step();
    chk("coinc pre count", {28'b0, queue_count}, 32'd1);
    chk("coinc pre addr", icache_addr, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    icache_instr = 32'h204 | TAG;
    step();
    redirect_valid = 1'b0;
    icache_valid = 1'b0;
    chk("coinc count", {28'b0, queue_count}, 32'd0);
    chk("coinc dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("coinc req", {31'b0, icache_req}, 32'd0);
    step();
    chk("coinc next req", {31'b0, icache_req}, 32'd1);
    chk("coinc next addr", icache_addr, 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
